hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the 5-stage MIPS pipeline.
//  - Selects ALU operand sources for the ID/EX instruction, with per-operand priority EX/MEM > MEM/WB.
//  - Detects load-use hazards and stalls.
//  - Runs a scoreboard for the multi-cycle multiply/divide unit (MDU): stalls dependent and structural conflicts.
//  - Keeps a saturating stall-cycle counter.
//  Drives the PC write enable, the IF/ID write enable, the ID/EX bubble and the forwarding muxes.
// PARAMETERS
//  REG_AW   5   register index width (2**REG_AW architectural registers; register 0 is hardwired zero)
//  MDU_LAT  4   MDU latency in cycles from issue to result write-back (>=2, <=15)
//  CNT_W    32  stall-counter width
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_i           in   1       asynchronous reset, active-low
//  ifid_rs_i       in   REG_AW  rs of the instruction in ID
//  ifid_rt_i       in   REG_AW  rt of the instruction in ID
//  ifid_mdu_i      in   1       instruction in ID is an MDU op
//  idex_rs_i       in   REG_AW  rs of the instruction in EX
//  idex_rt_i       in   REG_AW  rt of the instruction in EX
//  idex_memread_i  in   1       instruction in EX is a load
//  mdu_issue_i     in   1       MDU op leaves EX this cycle
//  mdu_rd_i        in   REG_AW  destination register of the issuing MDU op
//  exmem_rd_i      in   REG_AW  EX/MEM destination register
//  exmem_regw_i    in   1       EX/MEM RegWrite
//  memwb_rd_i      in   REG_AW  MEM/WB destination register
//  memwb_regw_i    in   1       MEM/WB RegWrite
//  forward_a_o     out  2       rs source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB
//  forward_b_o     out  2       rt source, same encoding
//  pc_write_o      out  1       PC write enable (0 = hold)
//  ifid_write_o    out  1       IF/ID write enable (0 = hold)
//  idex_flush_o    out  1       insert a bubble (zero control) into ID/EX
//  mdu_busy_o      out  1       an MDU op is in flight
//  stall_cnt_o     out  CNT_W   total stalled cycles, saturating
// BEHAVIOUR
//  Forwarding (combinational, each operand independent):
//   - exA = exmem_regw_i & (exmem_rd_i != 0) & (exmem_rd_i == idex_rs_i)
//   - memA = memwb_regw_i & (memwb_rd_i != 0) & (memwb_rd_i == idex_rs_i)
//   - forward_a_o = exA ? 10 : memA ? 01 : 00. forward_b_o is the same rule using idex_rt_i.
//   - Both operands may forward from the same stage at the same time.
//  Load-use (combinational):
//   - lu = idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i)
//  MDU scoreboard (sequential):
//   - State: busy (1 bit), cnt (4 bits), dst (REG_AW bits).
//   - IDLE: on mdu_issue_i, load busy=1, cnt=MDU_LAT-1 and dst=mdu_rd_i, then go to BUSY.
//   - BUSY: cnt decrements each cycle. When cnt==0 it returns to IDLE next cycle with busy=0.
//     A mdu_issue_i in that same cycle reloads and stays BUSY (back-to-back issue).
//   - A mdu_issue_i while BUSY with cnt!=0 is a protocol error. It is ignored; the state is not corrupted.
//   - mdu_dep = busy & (dst != 0) & (dst == ifid_rs_i | dst == ifid_rt_i)
//   - mdu_struct = busy & (cnt != 0) & ifid_mdu_i
//   - mdu_busy_o = busy
//  Stall:
//   - stall = lu | mdu_dep | mdu_struct
//   - pc_write_o = ifid_write_o = ~stall; idex_flush_o = stall.
//   - Forwarding outputs do not depend on stall.
//  Counter:
//   - stall_cnt_o increments by 1 on each clock edge where stall=1.
//   - It holds at 2**CNT_W-1 once reached.
//  Reset (rst_i low, asynchronous):
//   - busy=0, cnt=0, dst=0, stall_cnt_o=0.
//   - Combinational outputs follow their inputs with busy=0: forward_* = 00 and pc_write_o/ifid_write_o = 1
//     when no hazard inputs are active.
//   - Reset during BUSY aborts the MDU tracking immediately. Release is synchronous to the next clk_i edge.
//  Latency: forwarding and stall are zero-latency combinational. Scoreboard state updates on the edge after issue.
// TESTING
//  1. exmem rd=3 regw=1 and memwb rd=3 regw=1; idex rs=3 rt=3 -> forward_a=10, forward_b=10 (EX/MEM wins for both).
//  2. exmem rd=5 matches rs and memwb rd=6 matches rt -> forward_a=10, forward_b=01; with rd=0 on both -> 00/00.
//  3. idex_memread=1, idex_rt=7, ifid_rs=7 -> stall one cycle: pc_write=0, idex_flush=1, stall_cnt 0->1.
//  4. MDU issue rd=9, MDU_LAT=4; ID reads r9 -> stall for exactly 4 cycles, mdu_busy high 4 cycles, then release.
//  5. MDU issue, then an ifid_mdu op while cnt!=0 -> structural stall. Issue in the cnt==0 cycle -> back-to-back with no bubble.
//  6. Assert rst_i low mid-BUSY and mid-stall -> busy=0 and stall_cnt=0 at once, async; with CNT_W=2 the counter saturates at 3.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Forwarding, load-use and MDU-scoreboard hazard controller for the 5-stage MIPS pipeline.
// Forwarding and stall decisions are combinational; the MDU scoreboard and stall counter are registered.
module hazard_forward_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_mdu_i,
    input  logic [REG_AW-1:0] idex_rs_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic              idex_memread_i,
    input  logic              mdu_issue_i,
    input  logic [REG_AW-1:0] mdu_rd_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_regw_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_regw_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_flush_o,
    output logic              mdu_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [REG_AW-1:0] r_dst;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_busy;
    logic w_ex_a, w_mem_a, w_ex_b, w_mem_b;
    logic w_lu, w_mdu_dep, w_mdu_struct, w_stall;

    assign w_busy = (r_state == S_BUSY);

    always_comb begin
        w_ex_a  = exmem_regw_i && (exmem_rd_i != '0) && (exmem_rd_i == idex_rs_i);
        w_mem_a = memwb_regw_i && (memwb_rd_i != '0) && (memwb_rd_i == idex_rs_i);
        w_ex_b  = exmem_regw_i && (exmem_rd_i != '0) && (exmem_rd_i == idex_rt_i);
        w_mem_b = memwb_regw_i && (memwb_rd_i != '0) && (memwb_rd_i == idex_rt_i);
        forward_a_o = w_ex_a ? 2'b10 : (w_mem_a ? 2'b01 : 2'b00);
        forward_b_o = w_ex_b ? 2'b10 : (w_mem_b ? 2'b01 : 2'b00);
    end

    always_comb begin
        w_lu = idex_memread_i && (idex_rt_i != '0) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        w_mdu_dep = w_busy && (r_dst != '0) &&
                    ((r_dst == ifid_rs_i) || (r_dst == ifid_rt_i));
        w_mdu_struct = w_busy && (r_cnt != '0) && ifid_mdu_i;
        w_stall = w_lu || w_mdu_dep || w_mdu_struct;
    end

    assign pc_write_o   = ~w_stall;
    assign ifid_write_o = ~w_stall;
    assign idex_flush_o = w_stall;
    assign mdu_busy_o   = w_busy;
    assign stall_cnt_o  = r_stall_cnt;

    // An issue while BUSY with cnt!=0 is dropped so the tracked op is not lost.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dst   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu_issue_i) begin
                        r_state <= S_BUSY;
                        r_cnt   <= LAT_M1;
                        r_dst   <= mdu_rd_i;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (mdu_issue_i) begin
                            r_cnt <= LAT_M1;
                            r_dst <= mdu_rd_i;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomised plus directed bench for hazard_forward_ctrl against a cycle-count model of the hazard rules.
// A second instance with a 2-bit stall counter shares all inputs to exercise saturation.
module tb_hazard_forward_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MDU_LAT = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [REG_AW-1:0] ifid_rs_i = '0, ifid_rt_i = '0, idex_rs_i = '0, idex_rt_i = '0;
    logic [REG_AW-1:0] mdu_rd_i = '0, exmem_rd_i = '0, memwb_rd_i = '0;
    logic              ifid_mdu_i = 1'b0, idex_memread_i = 1'b0, mdu_issue_i = 1'b0;
    logic              exmem_regw_i = 1'b0, memwb_regw_i = 1'b0;

    logic [1:0]  forward_a_o, forward_b_o;
    logic        pc_write_o, ifid_write_o, idex_flush_o, mdu_busy_o;
    logic [31:0] stall_cnt_o;

    logic [1:0]  s_fa, s_fb;
    logic        s_pcw, s_ifw, s_flush, s_busy;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining busy cycles of the in-flight MDU op, its destination, total stalls.
    int          m_left = 0;
    int          m_dst  = 0;
    longint      m_stalls = 0;
    int          obs_stall = 0;
    int          obs_busy  = 0;

    hazard_forward_ctrl #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_mdu_i(ifid_mdu_i),
        .idex_rs_i(idex_rs_i), .idex_rt_i(idex_rt_i), .idex_memread_i(idex_memread_i),
        .mdu_issue_i(mdu_issue_i), .mdu_rd_i(mdu_rd_i),
        .exmem_rd_i(exmem_rd_i), .exmem_regw_i(exmem_regw_i),
        .memwb_rd_i(memwb_rd_i), .memwb_regw_i(memwb_regw_i),
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .idex_flush_o(idex_flush_o),
        .mdu_busy_o(mdu_busy_o), .stall_cnt_o(stall_cnt_o)
    );

    hazard_forward_ctrl #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_mdu_i(ifid_mdu_i),
        .idex_rs_i(idex_rs_i), .idex_rt_i(idex_rt_i), .idex_memread_i(idex_memread_i),
        .mdu_issue_i(mdu_issue_i), .mdu_rd_i(mdu_rd_i),
        .exmem_rd_i(exmem_rd_i), .exmem_regw_i(exmem_regw_i),
        .memwb_rd_i(memwb_rd_i), .memwb_regw_i(memwb_regw_i),
        .forward_a_o(s_fa), .forward_b_o(s_fb),
        .pc_write_o(s_pcw), .ifid_write_o(s_ifw), .idex_flush_o(s_flush),
        .mdu_busy_o(s_busy), .stall_cnt_o(s_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int fwd_sel(input int rd_ex, input bit w_ex, input int rd_mem,
                                   input bit w_mem, input int src);
        if (w_ex && rd_ex != 0 && rd_ex == src) return 2;
        if (w_mem && rd_mem != 0 && rd_mem == src) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        ifid_rs_i = '0; ifid_rt_i = '0; ifid_mdu_i = 1'b0;
        idex_rs_i = '0; idex_rt_i = '0; idex_memread_i = 1'b0;
        mdu_issue_i = 1'b0; mdu_rd_i = '0;
        exmem_rd_i = '0; exmem_regw_i = 1'b0; memwb_rd_i = '0; memwb_regw_i = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic step();
        bit lu, dep, st, stall;
        int ea, eb;
        longint sm;
        #1;
        ea = fwd_sel(int'(exmem_rd_i), exmem_regw_i, int'(memwb_rd_i), memwb_regw_i, int'(idex_rs_i));
        eb = fwd_sel(int'(exmem_rd_i), exmem_regw_i, int'(memwb_rd_i), memwb_regw_i, int'(idex_rt_i));
        lu  = idex_memread_i && idex_rt_i != 0 && (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i);
        dep = m_left > 0 && m_dst != 0 && (m_dst == int'(ifid_rs_i) || m_dst == int'(ifid_rt_i));
        st  = m_left > 1 && ifid_mdu_i;
        stall = lu || dep || st;
        sm = (m_stalls > 3) ? 3 : m_stalls;
        check("fwd_a", 64'(forward_a_o), 64'(ea));
        check("fwd_b", 64'(forward_b_o), 64'(eb));
        check("pc_write", 64'(pc_write_o), 64'(!stall));
        check("ifid_write", 64'(ifid_write_o), 64'(!stall));
        check("idex_flush", 64'(idex_flush_o), 64'(stall));
        check("mdu_busy", 64'(mdu_busy_o), 64'(m_left > 0));
        check("stall_cnt", 64'(stall_cnt_o), 64'(m_stalls));
        check("stall_cnt_sat", 64'(s_cnt), 64'(sm));
        if (idex_flush_o) obs_stall++;
        if (mdu_busy_o) obs_busy++;
        @(posedge clk_i);
        if (stall) m_stalls++;
        if (mdu_issue_i && m_left <= 1) begin
            m_left = MDU_LAT;
            m_dst  = int'(mdu_rd_i);
        end else if (m_left > 0) begin
            m_left--;
        end
        @(negedge clk_i);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
    task automatic async_reset();
        #2 rst_i = 1'b0;
        #1;
        check("rst_busy", 64'(mdu_busy_o), 64'd0);
        check("rst_cnt", 64'(stall_cnt_o), 64'd0);
        check("rst_cnt_sat", 64'(s_cnt), 64'd0);
        m_left = 0; m_dst = 0; m_stalls = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk_i);
        #1;
        check("reset_busy", 64'(mdu_busy_o), 64'd0);
        check("reset_cnt", 64'(stall_cnt_o), 64'd0);
        check("reset_pcw", 64'(pc_write_o), 64'd1);
        check("reset_fwd", 64'({forward_a_o, forward_b_o}), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Both operands from EX/MEM when both stages target the same register.
        exmem_rd_i = 5'd3; exmem_regw_i = 1'b1; memwb_rd_i = 5'd3; memwb_regw_i = 1'b1;
        idex_rs_i = 5'd3; idex_rt_i = 5'd3;
        step();
        exmem_rd_i = 5'd5; memwb_rd_i = 5'd6; idex_rs_i = 5'd5; idex_rt_i = 5'd6;
        step();
        exmem_rd_i = '0; memwb_rd_i = '0; idex_rs_i = '0; idex_rt_i = '0;
        step();
        clear_inputs();

        // Load-use single-cycle stall.
        idex_memread_i = 1'b1; idex_rt_i = 5'd7; ifid_rs_i = 5'd7;
        step();
        clear_inputs();
        step();

        // MDU dependency: ID reads the MDU destination for the whole latency.
        mdu_issue_i = 1'b1; mdu_rd_i = 5'd9;
        step();
        clear_inputs();
        ifid_rs_i = 5'd9;
        obs_stall = 0; obs_busy = 0;
        for (int i = 0; i < MDU_LAT + 2; i++) step();
        check("mdu_dep_stall_cycles", 64'(obs_stall), 64'(MDU_LAT));
        check("mdu_busy_cycles", 64'(obs_busy), 64'(MDU_LAT));
        clear_inputs();

        // Structural stall, then back-to-back issue in the cnt==0 cycle.
        mdu_issue_i = 1'b1; mdu_rd_i = 5'd4;
        step();
        mdu_issue_i = 1'b0; ifid_mdu_i = 1'b1;
        step();
        ifid_mdu_i = 1'b0;
        step();
        step();
        mdu_issue_i = 1'b1; mdu_rd_i = 5'd2; ifid_mdu_i = 1'b1;
        step();
        clear_inputs();
        step();

        // Saturate the 2-bit counter, then reset mid-BUSY and mid-stall.
        idex_memread_i = 1'b1; idex_rt_i = 5'd1; ifid_rt_i = 5'd1;
        for (int i = 0; i < 5; i++) step();
        mdu_issue_i = 1'b1; mdu_rd_i = 5'd8;
        step();
        async_reset();
        clear_inputs();
        step();

        for (int i = 0; i < 400; i++) begin
            ifid_rs_i = REG_AW'($urandom_range(0, 7));
            ifid_rt_i = REG_AW'($urandom_range(0, 7));
            ifid_mdu_i = ($urandom_range(0, 2) == 0);
            idex_rs_i = REG_AW'($urandom_range(0, 7));
            idex_rt_i = REG_AW'($urandom_range(0, 7));
            idex_memread_i = ($urandom_range(0, 2) == 0);
            mdu_issue_i = ($urandom_range(0, 3) == 0);
            mdu_rd_i = REG_AW'($urandom_range(0, 7));
            exmem_rd_i = REG_AW'($urandom_range(0, 7));
            exmem_regw_i = $urandom_range(0, 1) == 1;
            memwb_rd_i = REG_AW'($urandom_range(0, 7));
            memwb_regw_i = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 59) == 0) async_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
